// File: rtl/ctrl_pipe_hazard_pkg.sv
// ctrl_pipe_pkg: control-bit indices, bubble constants and forwarding-select encodings for ctrl_pipe_hazard.
package ctrl_pipe_pkg;
  localparam int EXE_REGDST = 0;
  localparam int EXE_ALUSRC = 1;
  localparam int EXE_ALUOP = 2;
  localparam int MEM_READ = 0;
  localparam int MEM_WRITE = 1;
  localparam int MEM_BRANCH = 2;
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEM2REG = 1;
  localparam logic [3:0] BUBBLE_EXE = 4'b0000;
  localparam logic [2:0] BUBBLE_MEM = 3'b000;
  localparam logic [1:0] BUBBLE_WB = 2'b00;
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;
endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// ctrl_pipe_hazard_if: ID-side inputs and stage-qualified control outputs of ctrl_pipe_hazard.
// Statistics counters exist only when CTRL_PIPE_STATS_EN is defined.
interface ctrl_pipe_hazard_if #(
  parameter int REG_AW = 5
`ifdef CTRL_PIPE_STATS_EN
  , parameter int CNT_W = 16
`endif
);
  logic [31:0]       id_instr;
  logic [3:0]        id_ctrl_exe;
  logic [2:0]        id_ctrl_mem;
  logic [1:0]        id_ctrl_wb;
  logic              id_jump;
  logic              id_exception;
  logic [1:0]        id_datamem;
  logic [1:0]        id_reg2;
  logic              ex_branch_taken;
  logic [3:0]        ex_ctrl_exe;
  logic [REG_AW-1:0] ex_dst;
  logic [2:0]        mem_ctrl_mem;
  logic [1:0]        mem_datamem;
  logic [1:0]        mem_reg2;
  logic [REG_AW-1:0] mem_dst;
  logic [1:0]        wb_ctrl_wb;
  logic [REG_AW-1:0] wb_dst;
  logic              stall;
  logic              flush_if_id;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              exc_valid;
`ifdef CTRL_PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif
  modport master (
    output id_instr, id_ctrl_exe, id_ctrl_mem, id_ctrl_wb, id_jump, id_exception,
           id_datamem, id_reg2, ex_branch_taken,
    input  ex_ctrl_exe, ex_dst, mem_ctrl_mem, mem_datamem, mem_reg2, mem_dst,
           wb_ctrl_wb, wb_dst, stall, flush_if_id, fwd_a, fwd_b, exc_valid
`ifdef CTRL_PIPE_STATS_EN
           , stall_cnt, flush_cnt
`endif
  );
  modport slave (
    input  id_instr, id_ctrl_exe, id_ctrl_mem, id_ctrl_wb, id_jump, id_exception,
           id_datamem, id_reg2, ex_branch_taken,
    output ex_ctrl_exe, ex_dst, mem_ctrl_mem, mem_datamem, mem_reg2, mem_dst,
           wb_ctrl_wb, wb_dst, stall, flush_if_id, fwd_a, fwd_b, exc_valid
`ifdef CTRL_PIPE_STATS_EN
           , stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// ctrl_fwd_unit: combinational forwarding select for the EX-stage source registers.
module ctrl_fwd_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_dst,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b
);
  // The younger EX/MEM result shadows MEM/WB; a zero destination never matches.
  function automatic fwd_sel_e pick(input logic [REG_AW-1:0] src, input logic mem_we,
                                    input logic [REG_AW-1:0] mem_dst, input logic wb_we,
                                    input logic [REG_AW-1:0] wb_dst);
    return (mem_we && mem_dst != '0 && mem_dst == src) ? FWD_EXMEM :
           (wb_we && wb_dst != '0 && wb_dst == src) ? FWD_MEMWB : FWD_RF;
  endfunction
  assign o_fwd_a = pick(i_ex_rs, i_mem_we, i_mem_dst, i_wb_we, i_wb_dst);
  assign o_fwd_b = pick(i_ex_rt, i_mem_we, i_mem_dst, i_wb_we, i_wb_dst);
endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: ID/EX, EX/MEM, MEM/WB control pipeline with stall/flush/exception handling and forwarding.
// Define CTRL_PIPE_STATS_EN to add saturating stall_cnt/flush_cnt outputs.
module ctrl_pipe_hazard
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW = 5
`ifdef CTRL_PIPE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_pipe_hazard_if.slave bus
);
  logic [REG_AW-1:0] w_id_rs, w_id_rt, w_id_rd, w_id_dst;
  logic              w_hz, w_bt, w_bubble, w_stall, w_flush;
  logic [3:0]        r_ex_exe;
  logic [2:0]        r_ex_mem;
  logic [1:0]        r_ex_wb, r_ex_datamem, r_ex_reg2;
  logic [REG_AW-1:0] r_ex_dst, r_ex_rs, r_ex_rt;
  logic [2:0]        r_mem_mem;
  logic [1:0]        r_mem_wb, r_mem_datamem, r_mem_reg2;
  logic [REG_AW-1:0] r_mem_dst;
  logic [1:0]        r_wb_wb;
  logic [REG_AW-1:0] r_wb_dst;
  logic              r_exc;
  assign w_id_rs  = bus.id_instr[21 +: REG_AW];
  assign w_id_rt  = bus.id_instr[16 +: REG_AW];
  assign w_id_rd  = bus.id_instr[11 +: REG_AW];
  assign w_id_dst = bus.id_ctrl_exe[EXE_REGDST] ? w_id_rd : w_id_rt;
  assign w_hz     = r_ex_mem[MEM_READ] && r_ex_dst != '0 && (r_ex_dst == w_id_rs || r_ex_dst == w_id_rt);
  assign w_bt     = bus.ex_branch_taken;
  // Order of precedence: branch redirect, exception, load-use stall, jump.
  assign w_bubble = w_bt || bus.id_exception || w_hz;
  assign w_stall  = w_hz && !w_bt && !bus.id_exception;
  assign w_flush  = w_bt || bus.id_exception || (bus.id_jump && !w_hz);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_exe      <= BUBBLE_EXE;
      r_ex_mem      <= BUBBLE_MEM;
      r_ex_wb       <= BUBBLE_WB;
      r_ex_datamem  <= '0;
      r_ex_reg2     <= '0;
      r_ex_dst      <= '0;
      r_ex_rs       <= '0;
      r_ex_rt       <= '0;
      r_mem_mem     <= BUBBLE_MEM;
      r_mem_wb      <= BUBBLE_WB;
      r_mem_datamem <= '0;
      r_mem_reg2    <= '0;
      r_mem_dst     <= '0;
      r_wb_wb       <= BUBBLE_WB;
      r_wb_dst      <= '0;
      r_exc         <= 1'b0;
    end else begin
      r_ex_exe      <= w_bubble ? BUBBLE_EXE : bus.id_ctrl_exe;
      r_ex_mem      <= w_bubble ? BUBBLE_MEM : bus.id_ctrl_mem;
      // A jump travels down the pipe but must never write the register file.
      r_ex_wb       <= w_bubble ? BUBBLE_WB : (bus.id_ctrl_wb & ~{1'b0, bus.id_jump});
      r_ex_datamem  <= w_bubble ? 2'b00 : bus.id_datamem;
      r_ex_reg2     <= w_bubble ? 2'b00 : bus.id_reg2;
      r_ex_dst      <= w_bubble ? '0 : w_id_dst;
      r_ex_rs       <= w_bubble ? '0 : w_id_rs;
      r_ex_rt       <= w_bubble ? '0 : w_id_rt;
      r_mem_mem     <= r_ex_mem;
      r_mem_wb      <= r_ex_wb;
      r_mem_datamem <= r_ex_datamem;
      r_mem_reg2    <= r_ex_reg2;
      r_mem_dst     <= r_ex_dst;
      r_wb_wb       <= r_mem_wb;
      r_wb_dst      <= r_mem_dst;
      r_exc         <= bus.id_exception && !w_bt;
    end
  end
  ctrl_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .i_ex_rs  (r_ex_rs),
    .i_ex_rt  (r_ex_rt),
    .i_mem_we (r_mem_wb[WB_REGWRITE]),
    .i_mem_dst(r_mem_dst),
    .i_wb_we  (r_wb_wb[WB_REGWRITE]),
    .i_wb_dst (r_wb_dst),
    .o_fwd_a  (bus.fwd_a),
    .o_fwd_b  (bus.fwd_b)
  );
  assign bus.ex_ctrl_exe  = r_ex_exe;
  assign bus.ex_dst       = r_ex_dst;
  assign bus.mem_ctrl_mem = r_mem_mem;
  assign bus.mem_datamem  = r_mem_datamem;
  assign bus.mem_reg2     = r_mem_reg2;
  assign bus.mem_dst      = r_mem_dst;
  assign bus.wb_ctrl_wb   = r_wb_wb;
  assign bus.wb_dst       = r_wb_dst;
  assign bus.stall        = w_stall;
  assign bus.flush_if_id  = w_flush;
  assign bus.exc_valid    = r_exc;
`ifdef CTRL_PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard: directed and randomized checks of ctrl_pipe_hazard against an event-level reference model.
module tb_ctrl_pipe_hazard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
`ifdef CTRL_PIPE_STATS_EN
  localparam int CNT_W = 4;
  ctrl_pipe_hazard_if #(.REG_AW(5), .CNT_W(CNT_W)) bus ();
  ctrl_pipe_hazard #(.REG_AW(5), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [CNT_W-1:0] m_sc, m_fc;
`else
  ctrl_pipe_hazard_if #(.REG_AW(5)) bus ();
  ctrl_pipe_hazard #(.REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  typedef struct packed {
    logic [3:0] exe;
    logic [2:0] mem;
    logic [1:0] wb, dm, r2;
    logic [4:0] dst, rs, rt;
  } ins_t;
  typedef enum {EV_NONE, EV_FLUSH, EV_EXC, EV_STALL, EV_JUMP} ev_e;
  ins_t p [3];
  logic m_exc;
  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 11'd0};
  endfunction

  function automatic ev_e classify();
    logic [4:0] rs, rt;
    rs = bus.id_instr[25:21];
    rt = bus.id_instr[20:16];
    if (bus.ex_branch_taken) return EV_FLUSH;
    if (bus.id_exception) return EV_EXC;
    if (p[0].mem[0] && p[0].dst != 0 && (p[0].dst == rs || p[0].dst == rt)) return EV_STALL;
    if (bus.id_jump) return EV_JUMP;
    return EV_NONE;
  endfunction

  function automatic logic [1:0] mfwd(input logic [4:0] s);
    if (p[1].wb[0] && p[1].dst != 0 && p[1].dst == s) return 2'b10;
    if (p[2].wb[0] && p[2].dst != 0 && p[2].dst == s) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_all();
    ev_e ev;
    ev = classify();
    chk("ex_ctrl_exe", 32'(bus.ex_ctrl_exe), 32'(p[0].exe));
    chk("ex_dst", 32'(bus.ex_dst), 32'(p[0].dst));
    chk("mem_ctrl_mem", 32'(bus.mem_ctrl_mem), 32'(p[1].mem));
    chk("mem_datamem", 32'(bus.mem_datamem), 32'(p[1].dm));
    chk("mem_reg2", 32'(bus.mem_reg2), 32'(p[1].r2));
    chk("mem_dst", 32'(bus.mem_dst), 32'(p[1].dst));
    chk("wb_ctrl_wb", 32'(bus.wb_ctrl_wb), 32'(p[2].wb));
    chk("wb_dst", 32'(bus.wb_dst), 32'(p[2].dst));
    chk("stall", 32'(bus.stall), 32'(ev == EV_STALL));
    chk("flush_if_id", 32'(bus.flush_if_id), 32'(ev == EV_FLUSH || ev == EV_EXC || ev == EV_JUMP));
    chk("fwd_a", 32'(bus.fwd_a), 32'(mfwd(p[0].rs)));
    chk("fwd_b", 32'(bus.fwd_b), 32'(mfwd(p[0].rt)));
    chk("exc_valid", 32'(bus.exc_valid), 32'(m_exc));
`ifdef CTRL_PIPE_STATS_EN
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_sc));
    chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_fc));
`endif
  endtask

  task automatic drive(input logic [31:0] ins, input logic [3:0] exe, input logic [2:0] mem,
                       input logic [1:0] wb, input logic j, input logic x, input logic bt);
    bus.id_instr = ins;
    bus.id_ctrl_exe = exe;
    bus.id_ctrl_mem = mem;
    bus.id_ctrl_wb = wb;
    bus.id_jump = j;
    bus.id_exception = x;
    bus.ex_branch_taken = bt;
    bus.id_datamem = 2'($urandom);
    bus.id_reg2 = 2'($urandom);
    #2;
    check_all();
  endtask

  task automatic tick();
    ev_e ev;
    ins_t d;
    ev = classify();
    d.exe = bus.id_ctrl_exe;
    d.mem = bus.id_ctrl_mem;
    d.wb = bus.id_ctrl_wb & {1'b1, ~bus.id_jump};
    d.dm = bus.id_datamem;
    d.r2 = bus.id_reg2;
    d.rs = bus.id_instr[25:21];
    d.rt = bus.id_instr[20:16];
    d.dst = bus.id_ctrl_exe[0] ? bus.id_instr[15:11] : bus.id_instr[20:16];
    @(posedge clk);
    p[2] = p[1];
    p[1] = p[0];
    p[0] = (ev == EV_FLUSH || ev == EV_EXC || ev == EV_STALL) ? '0 : d;
    m_exc = (ev == EV_EXC);
`ifdef CTRL_PIPE_STATS_EN
    if (ev == EV_STALL && m_sc != '1) m_sc++;
    if ((ev == EV_FLUSH || ev == EV_EXC || ev == EV_JUMP) && m_fc != '1) m_fc++;
`endif
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) p[i] = '0;
    m_exc = 1'b0;
`ifdef CTRL_PIPE_STATS_EN
    m_sc = '0;
    m_fc = '0;
`endif
  endtask

  initial begin
    logic [31:0] ri;
    logic [3:0] re;
    logic [2:0] rm;
    logic [1:0] rw;
    logic rj, rx, rb, held;
    model_reset();
    bus.id_instr = '0;
    bus.id_ctrl_exe = '0;
    bus.id_ctrl_mem = '0;
    bus.id_ctrl_wb = '0;
    bus.id_jump = 1'b0;
    bus.id_exception = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.id_datamem = '0;
    bus.id_reg2 = '0;
    #2;
    check_all();
    #5 rst_n = 1'b1;
    // lw $2,0($1) ; add $3,$2,$4
    drive(mk(1, 2, 0), 4'b0010, 3'b001, 2'b11, 0, 0, 0);
    tick();
    drive(mk(2, 4, 3), 4'b1001, 3'b000, 2'b01, 0, 0, 0);
    chk("lu_stall", 32'(bus.stall), 32'd1);
    tick();
    drive(mk(2, 4, 3), 4'b1001, 3'b000, 2'b01, 0, 0, 0);
    chk("lu_bubble", 32'(bus.ex_ctrl_exe), 32'd0);
    chk("lu_stall_once", 32'(bus.stall), 32'd0);
    tick();
    drive(mk(0, 0, 0), 4'b0000, 3'b000, 2'b00, 0, 0, 0);
    chk("lu_fwd_a", 32'(bus.fwd_a), 32'b01);
    tick();
    // add $5,$1,$1 ; sub $6,$5,$5
    drive(mk(1, 1, 5), 4'b1001, 3'b000, 2'b01, 0, 0, 0);
    tick();
    drive(mk(5, 5, 6), 4'b1001, 3'b000, 2'b01, 0, 0, 0);
    chk("as_stall", 32'(bus.stall), 32'd0);
    tick();
    drive(mk(0, 0, 0), 4'b0000, 3'b000, 2'b00, 0, 0, 0);
    chk("as_fwd_a", 32'(bus.fwd_a), 32'b10);
    chk("as_fwd_b", 32'(bus.fwd_b), 32'b10);
    tick();
    // redirect while ID holds a load-use hazard
    drive(mk(3, 7, 0), 4'b0010, 3'b001, 2'b11, 0, 0, 0);
    tick();
    drive(mk(7, 1, 8), 4'b1001, 3'b000, 2'b01, 0, 0, 1);
    chk("br_flush", 32'(bus.flush_if_id), 32'd1);
    chk("br_stall", 32'(bus.stall), 32'd0);
    tick();
    drive(mk(0, 0, 0), 4'b0000, 3'b000, 2'b00, 0, 0, 0);
    chk("br_bubble", 32'(bus.ex_ctrl_exe), 32'd0);
    tick();
    // decode exception on R-type with rd=0
    drive(mk(1, 2, 0), 4'b1001, 3'b000, 2'b01, 0, 1, 0);
    chk("exc_flush", 32'(bus.flush_if_id), 32'd1);
    tick();
    drive(mk(0, 0, 0), 4'b0000, 3'b000, 2'b00, 0, 0, 0);
    chk("exc_pulse", 32'(bus.exc_valid), 32'd1);
    tick();
    drive(mk(0, 0, 0), 4'b0000, 3'b000, 2'b00, 0, 0, 0);
    chk("exc_once", 32'(bus.exc_valid), 32'd0);
    tick();
    chk("exc_wb", 32'(bus.wb_ctrl_wb), 32'd0);
    // jump enters ID/EX without a register write
    drive(mk(0, 0, 31), 4'b1001, 3'b000, 2'b01, 1, 0, 0);
    chk("jmp_flush", 32'(bus.flush_if_id), 32'd1);
    tick();
    // three live instructions plus a pending exception, then async reset
    drive(mk(1, 2, 9), 4'b1001, 3'b000, 2'b01, 0, 0, 0);
    tick();
    drive(mk(2, 3, 10), 4'b1001, 3'b000, 2'b01, 0, 0, 0);
    tick();
    drive(mk(9, 10, 11), 4'b1001, 3'b000, 2'b01, 0, 1, 0);
    tick();
    chk("pre_rst_exc", 32'(bus.exc_valid), 32'd1);
    rst_n = 1'b0;
    bus.id_exception = 1'b0;
    bus.id_jump = 1'b0;
    bus.ex_branch_taken = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_mem", 32'(bus.mem_ctrl_mem), 32'd0);
    chk("rst_exc", 32'(bus.exc_valid), 32'd0);
    #2 rst_n = 1'b1;
    held = 1'b0;
    ri = '0; re = '0; rm = '0; rw = '0; rj = 0; rx = 0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        ri = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 11'($urandom)};
        re = 4'($urandom);
        rm = 3'($urandom);
        rw = 2'($urandom);
        rj = ($urandom_range(0, 7) == 0);
        rx = ($urandom_range(0, 9) == 0);
      end
      rb = held ? 1'b0 : ($urandom_range(0, 7) == 0);
      drive(ri, re, rm, rw, rj, rx, rb);
      held = (classify() == EV_STALL);
      tick();
    end
`ifdef CTRL_PIPE_STATS_EN
    begin
      int k = 0;
      int n = 0;
      int guard = 0;
      while (n < (1 << CNT_W) + 3 && guard < 1000) begin
        drive(k[0] ? mk(1, 2, 0) : mk(2, 1, 0), 4'b0010, 3'b001, 2'b11, 0, 0, 0);
        if (classify() == EV_STALL) n++;
        else k++;
        tick();
        guard++;
      end
      chk("stall_sat", 32'(bus.stall_cnt), 32'({CNT_W{1'b1}}));
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
